// File: rtl/mux_n_stream.sv
// N:1 valid/ready stream mux with one registered output stage, manual or round-robin grant.
// Define MUX_N_STREAM_LOCK_EN to add in_last/out_last and hold the round-robin grant for whole packets.
module mux_n_stream #(
  parameter int  NUM_CH = 4,
  parameter int  DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef MUX_N_STREAM_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  last_gnt;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] sel_data;
  logic              found;
  logic              load_en;
  logic              xfer;

`ifdef MUX_N_STREAM_LOCK_EN
  logic locked;
`endif

  assign load_en  = !out_valid || out_ready;
  assign in_ready = gnt & {NUM_CH{load_en & rst_n}};
  assign xfer     = |in_ready;
  assign sel_data = in_data[gnt_idx*DATA_W +: DATA_W];

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    if (!mode) begin
      if (int'(sel) < NUM_CH && in_valid[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
`ifdef MUX_N_STREAM_LOCK_EN
    end else if (locked) begin
      if (in_valid[last_gnt]) begin
        gnt[last_gnt] = 1'b1;
        gnt_idx       = last_gnt;
      end
`endif
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = SEL_W'((int'(last_gnt) + k) % NUM_CH);
        if (!found && in_valid[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_ch   <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= SEL_W'(NUM_CH - 1);
    end else if (mode && xfer) begin
      last_gnt <= gnt_idx;
    end
  end

`ifdef MUX_N_STREAM_LOCK_EN
  // While locked, last_gnt names the channel owning the open packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (!mode) begin
      locked <= 1'b0;
    end else if (xfer) begin
      locked <= !in_last[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last <= 1'b0;
    end else if (load_en && xfer) begin
      out_last <= in_last[gnt_idx];
    end
  end
`endif

endmodule
